// File: rtl/vsq_stage_buffer_if.sv
// Handshake and read-port bundle between the accumulator stream, the staging buffer and the
// quantizer. The buffer uses the slave modport; the upstream/quantizer side uses master.
interface vsq_stage_buffer_if #(
    parameter int unsigned LANES = 16,
    parameter int unsigned DW    = 18,
    parameter int unsigned AW    = 6
);
    logic                  i_valid;
    logic [LANES*DW-1:0]   i_data;
    logic                  o_ready;
    logic                  o_start;
    logic                  i_finish;
    logic [AW-1:0]         i_buf_addr;
    logic [LANES*DW-1:0]   o_buf_data;
    logic [1:0]            o_full;
    logic                  o_overflow;

    modport master (
        output i_valid,
        output i_data,
        output i_finish,
        output i_buf_addr,
        input  o_ready,
        input  o_start,
        input  o_buf_data,
        input  o_full,
        input  o_overflow
    );

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_finish,
        input  i_buf_addr,
        output o_ready,
        output o_start,
        output o_buf_data,
        output o_full,
        output o_overflow
    );
endinterface

// File: rtl/vsq_stage_buffer.sv
// Ping-pong staging buffer in front of the quantizer: the writer fills one 64-vector bank while
// the quantizer drains the other through a zero-latency random-access read port.
module vsq_stage_buffer #(
    parameter int unsigned LANES = 16,
    parameter int unsigned DW    = 18,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input logic                i_clk,
    input logic                i_rst,
    vsq_stage_buffer_if.slave  bus
);
    typedef enum logic {
        RIdle,
        RDrain
    } rd_state_e;

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    logic [LANES*DW-1:0] bank_mem [2][DEPTH];

    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    logic          overflow_q, overflow_d;
    rd_state_e     rd_state_q, rd_state_d;

    logic ready;
    logic accept;
    logic release_bank;

    // Ready depends on registers only, so there is no valid-to-ready combinational path.
    assign ready        = !full_q[wr_bank_q];
    assign accept       = bus.i_valid && ready;
    assign release_bank = (rd_state_q == RDrain) && bus.i_finish;

    // Write-side pointers, flags and sticky overflow.
    always_comb begin
        wr_bank_d  = wr_bank_q;
        wr_addr_d  = wr_addr_q;
        rd_bank_d  = rd_bank_q;
        full_d     = full_q;
        overflow_d = overflow_q;

        if (release_bank) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end

        if (accept) begin
            if (wr_addr_q == LastAddr) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_addr_d         = '0;
            end else begin
                wr_addr_d = wr_addr_q + AW'(1);
            end
        end else if (bus.i_valid) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_bank_q  <= 1'b0;
            wr_addr_q  <= '0;
            rd_bank_q  <= 1'b0;
            full_q     <= 2'b00;
            overflow_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            wr_addr_q  <= wr_addr_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is intentionally not reset; writes are suppressed while reset is held.
    always_ff @(posedge i_clk) begin
        if (!i_rst && accept) begin
            bank_mem[wr_bank_q][wr_addr_q] <= bus.i_data;
        end
    end

    // Reader FSM: state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_state_q <= RIdle;
        end else begin
            rd_state_q <= rd_state_d;
        end
    end

    // Reader FSM: next state.
    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            RIdle: begin
                if (full_q[rd_bank_q]) begin
                    rd_state_d = RDrain;
                end
            end
            RDrain: begin
                if (bus.i_finish) begin
                    rd_state_d = RIdle;
                end
            end
            default: rd_state_d = RIdle;
        endcase
    end

    // Reader FSM: outputs. Start lasts one cycle because IDLE always leaves when it fires.
    always_comb begin
        bus.o_start = 1'b0;
        unique case (rd_state_q)
            RIdle:   bus.o_start = full_q[rd_bank_q];
            RDrain:  bus.o_start = 1'b0;
            default: bus.o_start = 1'b0;
        endcase
    end

    assign bus.o_ready    = ready;
    assign bus.o_full     = full_q;
    assign bus.o_overflow = overflow_q;
    assign bus.o_buf_data = bank_mem[rd_bank_q][bus.i_buf_addr];

endmodule

// File: tb/tb_vsq_stage_buffer.sv
// Randomized bench for vsq_stage_buffer; a counting model (vectors accepted, banks released)
// predicts every output each cycle.
module tb_vsq_stage_buffer;
    localparam int unsigned LANES = 16;
    localparam int unsigned DW    = 18;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;
    localparam int unsigned VW    = LANES * DW;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    vsq_stage_buffer_if #(.LANES(LANES), .DW(DW), .AW(AW)) bus ();

    vsq_stage_buffer #(
        .LANES(LANES),
        .DW   (DW),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Model: everything derives from how many vectors were accepted and banks released.
    int          m_acc = 0;
    int          m_rel = 0;
    bit          m_drain = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_known = 1'b0;
    logic [VW-1:0] m_mem [2][DEPTH];
    int          rd_cnt = 0;
    int          start_seen = 0;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int m_filled();
        return m_acc / DEPTH;
    endfunction

    function automatic bit m_ready();
        return (m_filled() - m_rel) < 2;
    endfunction

    function automatic logic [1:0] m_full();
        logic [1:0] f;
        int outstanding;
        f = 2'b00;
        outstanding = m_filled() - m_rel;
        if (outstanding >= 2) f = 2'b11;
        else if (outstanding == 1) f[m_rel % 2] = 1'b1;
        return f;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [VW-1:0] pattern_vec(input int n);
        logic [VW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*DW +: DW] = DW'(n * LANES + k);
        return v;
    endfunction

    // One clock cycle: drive, check mid-cycle, then advance the model at the edge.
    task automatic step(input bit rst, input bit valid, input logic [VW-1:0] data,
                        input bit rd_en, input bit fin_noise);
        bit fin;
        bit pre_drain;
        bit pre_ready;
        bit pre_start;
        int pre_filled;
        i_rst       = rst;
        bus.i_valid = valid;
        bus.i_data  = data;
        if (m_drain && rd_en) begin
            bus.i_buf_addr = AW'(rd_cnt);
            fin = (rd_cnt == DEPTH - 1);
        end else begin
            bus.i_buf_addr = AW'($urandom_range(0, DEPTH - 1));
            fin = fin_noise && !m_drain;
        end
        bus.i_finish = fin;
        #3;
        if (m_known) begin
            check("ready", VW'(bus.o_ready), VW'(m_ready()));
            check("start", VW'(bus.o_start), VW'(!m_drain && (m_filled() > m_rel)));
            check("full", VW'(bus.o_full), VW'(m_full()));
            check("overflow", VW'(bus.o_overflow), VW'(m_ovf));
            if (m_filled() > m_rel)
                check("buf_data", bus.o_buf_data, m_mem[m_rel % 2][bus.i_buf_addr]);
            if (bus.o_start === 1'b1) start_seen++;
        end
        pre_drain  = m_drain;
        pre_ready  = m_ready();
        pre_filled = m_filled();
        pre_start  = !m_drain && (pre_filled > m_rel);
        @(posedge i_clk);
        if (rst) begin
            m_acc   = 0;
            m_rel   = 0;
            m_drain = 1'b0;
            m_ovf   = 1'b0;
            rd_cnt  = 0;
            m_known = 1'b1;
        end else begin
            if (valid && pre_ready) begin
                m_mem[(m_acc / DEPTH) % 2][m_acc % DEPTH] = data;
                m_acc++;
            end else if (valid) begin
                m_ovf = 1'b1;
            end
            if (pre_drain) begin
                if (fin) begin
                    m_rel++;
                    m_drain = 1'b0;
                    rd_cnt  = 0;
                end else if (rd_en) begin
                    rd_cnt++;
                end
            end else if (pre_start) begin
                m_drain = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        logic [VW-1:0] held;
        logic [VW-1:0] lane_word;
        bit rd_en;

        bus.i_valid    = 1'b0;
        bus.i_data     = '0;
        bus.i_finish   = 1'b0;
        bus.i_buf_addr = '0;
        @(posedge i_clk);
        #1;

        // Reset held three cycles with valid high: nothing may be stored.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, rand_vec(), 1'b0, 1'b0);

        // Bank 0 with the lane pattern, reader held off.
        for (int n = 0; n < DEPTH; n++) step(1'b0, 1'b1, pattern_vec(n), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, rand_vec(), 1'b0, 1'b0);
        bus.i_buf_addr = AW'(DEPTH - 1);
        #1;
        lane_word = '0;
        lane_word[DW-1:0] = bus.o_buf_data[15*DW +: DW];
        check("lane15_addr63", lane_word, VW'(1023));
        check("start_once_bank0", VW'(start_seen), VW'(1));

        // Fill bank 1, then push into a full buffer to raise overflow.
        for (int n = 0; n < DEPTH; n++) step(1'b0, 1'b1, rand_vec(), 1'b0, 1'b0);
        held = rand_vec();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, held, 1'b0, 1'b0);

        // Release bank 0 while the writer holds its vector; it must land at bank 0 addr 0.
        for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 1'b1, held, 1'b1, 1'b0);
        for (int i = 0; i < 2 * DEPTH + 8; i++) step(1'b0, 1'b0, rand_vec(), 1'b1, 1'b0);

        // Random traffic with reader stalls, stray finishes and occasional resets.
        rd_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) rd_en = !rd_en;
            step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, rand_vec(), rd_en,
                 $urandom_range(0, 19) == 0);
        end

        // Reset mid-fill at address 37, then mid-drain; each refill yields one start.
        step(1'b1, 1'b0, rand_vec(), 1'b0, 1'b0);
        for (int n = 0; n < 37; n++) step(1'b0, 1'b1, rand_vec(), 1'b0, 1'b0);
        step(1'b1, 1'b1, rand_vec(), 1'b0, 1'b0);
        for (int n = 0; n < DEPTH; n++) step(1'b0, 1'b1, rand_vec(), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, rand_vec(), 1'b1, 1'b0);
        step(1'b1, 1'b0, rand_vec(), 1'b0, 1'b0);
        start_seen = 0;
        for (int n = 0; n < DEPTH; n++) step(1'b0, 1'b1, rand_vec(), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, rand_vec(), 1'b0, 1'b0);
        check("start_once_after_reset", VW'(start_seen), VW'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
